// File: rtl/stage3_bus_arbiter_if.sv
// ============================================================================
// Module   : stage3_bus_arbiter_if
// Brief    : Fetch, data and memory-side bus bundle for the pipeline bus arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stage3_bus_arbiter_if;
    logic [31:0] i_addr;
    logic        i_ren;
    logic [31:0] i_rdata;
    logic        i_busy;

    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ren;
    logic        d_wen;
    logic [3:0]  d_byte_en;
    logic [31:0] d_rdata;
    logic        d_busy;

    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ren;
    logic        m_wen;
    logic [3:0]  m_byte_en;
    logic [31:0] m_rdata;
    logic        m_busy;

    logic [1:0]  owner;

    // Arbiter side
    modport slave (
        input  i_addr, i_ren,
        input  d_addr, d_wdata, d_ren, d_wen, d_byte_en,
        input  m_rdata, m_busy,
        output i_rdata, i_busy,
        output d_rdata, d_busy,
        output m_addr, m_wdata, m_ren, m_wen, m_byte_en,
        output owner
    );

    // Pipeline + memory side, as seen by whatever surrounds the arbiter
    modport master (
        output i_addr, i_ren,
        output d_addr, d_wdata, d_ren, d_wen, d_byte_en,
        output m_rdata, m_busy,
        input  i_rdata, i_busy,
        input  d_rdata, d_busy,
        input  m_addr, m_wdata, m_ren, m_wen, m_byte_en,
        input  owner
    );
endinterface

`default_nettype wire

// File: rtl/stage3_bus_arbiter.sv
// ============================================================================
// Module   : stage3_bus_arbiter
// Brief    : Shares one memory bus between fetch (read-only) and data ports;
//            data has priority. Optional macro ARB_FAIRNESS_EN adds a fetch
//            anti-starvation guard limited by D_STREAK_MAX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage3_bus_arbiter #(
    parameter int D_STREAK_MAX = 4
) (
    input wire logic             CLK,
    input wire logic             nRST,
    stage3_bus_arbiter_if.slave  bus
);

    localparam logic [1:0] c_IDLE  = 2'b00;
    localparam logic [1:0] c_I_ACT = 2'b01;
    localparam logic [1:0] c_D_ACT = 2'b10;

    localparam logic [1:0] c_SEL_NONE  = 2'b00;
    localparam logic [1:0] c_SEL_FETCH = 2'b01;
    localparam logic [1:0] c_SEL_DATA  = 2'b10;

    if (D_STREAK_MAX < 1) begin : g_bad_streak_max
        $error("D_STREAK_MAX must be at least 1");
    end

    logic [1:0] state_q;
    logic [1:0] state_d;

    logic       w_i_req;
    logic       w_d_req;
    logic       w_fetch_fair;
    logic [1:0] w_sel;
    logic       w_sel_req;
    logic       w_done;

`ifdef ARB_FAIRNESS_EN
    localparam int                    c_STREAK_W   = $clog2(D_STREAK_MAX + 1);
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(D_STREAK_MAX);

    logic [c_STREAK_W-1:0] streak_q;
    logic [c_STREAK_W-1:0] streak_d;

    // Data completions only count against fetch while fetch is actually waiting
    always_comb begin : p_streak_next
        streak_d = streak_q;
        if (w_done) begin
            if ((w_sel == c_SEL_FETCH) || !w_i_req) begin
                streak_d = '0;
            end else if (streak_q != c_STREAK_MAX) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin : p_streak_reg
        if (!nRST) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign w_fetch_fair = (streak_q == c_STREAK_MAX) && w_i_req;
`else
    assign w_fetch_fair = 1'b0;
`endif

    assign w_i_req = bus.i_ren;
    assign w_d_req = bus.d_ren | bus.d_wen;

    // Holding reset selects nobody, which forces every request/busy output idle
    always_comb begin : p_select
        w_sel = c_SEL_NONE;
        if (nRST) begin
            case (state_q)
                c_IDLE: begin
                    if (w_fetch_fair) begin
                        w_sel = c_SEL_FETCH;
                    end else if (w_d_req) begin
                        w_sel = c_SEL_DATA;
                    end else if (w_i_req) begin
                        w_sel = c_SEL_FETCH;
                    end
                end
                c_I_ACT: w_sel = c_SEL_FETCH;
                c_D_ACT: w_sel = c_SEL_DATA;
                default: w_sel = c_SEL_NONE;
            endcase
        end
    end

    assign w_sel_req = ((w_sel == c_SEL_FETCH) && w_i_req) ||
                       ((w_sel == c_SEL_DATA)  && w_d_req);
    assign w_done    = w_sel_req && !bus.m_busy;

    always_ff @(posedge CLK) begin : p_state_reg
        if (!nRST) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (w_sel_req && bus.m_busy) begin
                    state_d = (w_sel == c_SEL_DATA) ? c_D_ACT : c_I_ACT;
                end
            end
            c_I_ACT, c_D_ACT: begin
                // Completion or a dropped request both release the bus
                if (!w_sel_req || !bus.m_busy) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin : p_outputs
        bus.m_addr    = '0;
        bus.m_wdata   = '0;
        bus.m_ren     = 1'b0;
        bus.m_wen     = 1'b0;
        bus.m_byte_en = 4'h0;
        bus.i_busy    = 1'b1;
        bus.i_rdata   = '0;
        bus.d_busy    = 1'b1;
        bus.d_rdata   = '0;
        if (w_sel_req) begin
            if (w_sel == c_SEL_FETCH) begin
                bus.m_addr    = bus.i_addr;
                bus.m_ren     = 1'b1;
                bus.m_byte_en = 4'hF;
                if (w_done) begin
                    bus.i_busy  = 1'b0;
                    bus.i_rdata = bus.m_rdata;
                end
            end else begin
                bus.m_addr    = bus.d_addr;
                bus.m_wdata   = bus.d_wdata;
                bus.m_ren     = bus.d_ren;
                bus.m_wen     = bus.d_wen;
                bus.m_byte_en = bus.d_byte_en;
                if (w_done) begin
                    bus.d_busy  = 1'b0;
                    bus.d_rdata = bus.m_rdata;
                end
            end
        end
    end

    assign bus.owner = state_q;

endmodule

`default_nettype wire

// File: tb/tb_stage3_bus_arbiter.sv
// ============================================================================
// Module   : tb_stage3_bus_arbiter
// Brief    : Scoreboard bench for stage3_bus_arbiter (honours ARB_FAIRNESS_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage3_bus_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    logic CLK;
    logic nRST;

    stage3_bus_arbiter_if bus ();

    stage3_bus_arbiter #(.D_STREAK_MAX(4)) u_dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int   n_chk  = 0;
    int   n_fail = 0;
    exp_t iq[$];
    exp_t dq[$];
    logic [7:0] log_q[$];
    logic exp_fetch;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_i(input logic [31:0] addr, input logic [31:0] rdata);
        exp_t e;
        e.addr = addr; e.wdata = '0; e.wen = 1'b0; e.be = 4'hF; e.rdata = rdata;
        iq.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wen, input logic [3:0] be, input logic [31:0] rdata);
        exp_t e;
        e.addr = addr; e.wdata = wdata; e.wen = wen; e.be = be; e.rdata = rdata;
        dq.push_back(e);
    endtask

    // Scoreboard: every completion the DUT signals must match the next queued expectation
    always @(negedge CLK) begin : p_monitor
        exp_t e;
        if (nRST) begin
            if (!bus.i_busy) begin
                if (iq.size() == 0) begin
                    check_eq("i_unexpected_done", {31'b0, bus.i_busy}, 32'd1);
                end else begin
                    e = iq.pop_front();
                    check_eq("i_rdata",   bus.i_rdata,   e.rdata);
                    check_eq("i_m_addr",  bus.m_addr,    e.addr);
                    check_eq("i_m_ren",   {31'b0, bus.m_ren}, 32'd1);
                    check_eq("i_m_be",    {28'b0, bus.m_byte_en}, 32'hF);
                end
                log_q.push_back(8'h49);
            end
            if (!bus.d_busy) begin
                if (dq.size() == 0) begin
                    check_eq("d_unexpected_done", {31'b0, bus.d_busy}, 32'd1);
                end else begin
                    e = dq.pop_front();
                    check_eq("d_rdata",   bus.d_rdata,   e.rdata);
                    check_eq("d_m_addr",  bus.m_addr,    e.addr);
                    check_eq("d_m_wdata", bus.m_wdata,   e.wdata);
                    check_eq("d_m_wen",   {31'b0, bus.m_wen}, {31'b0, e.wen});
                    check_eq("d_m_ren",   {31'b0, bus.m_ren}, {31'b0, ~e.wen});
                    check_eq("d_m_be",    {28'b0, bus.m_byte_en}, {28'b0, e.be});
                end
                log_q.push_back(8'h44);
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        nRST = 1'b0;
        bus.i_addr = '0; bus.i_ren = 1'b0;
        bus.d_addr = '0; bus.d_wdata = '0; bus.d_ren = 1'b0; bus.d_wen = 1'b0; bus.d_byte_en = 4'h0;
        bus.m_rdata = '0; bus.m_busy = 1'b1;
        tick();

        // Reset held with both ports requesting
        bus.i_ren = 1'b1; bus.d_ren = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge CLK);
            check_eq("rst_m_ren",  {31'b0, bus.m_ren},  32'd0);
            check_eq("rst_m_wen",  {31'b0, bus.m_wen},  32'd0);
            check_eq("rst_i_busy", {31'b0, bus.i_busy}, 32'd1);
            check_eq("rst_d_busy", {31'b0, bus.d_busy}, 32'd1);
            check_eq("rst_owner",  {30'b0, bus.owner},  32'd0);
            tick();
        end
        nRST = 1'b1; bus.i_ren = 1'b0; bus.d_ren = 1'b0;
        @(negedge CLK);
        check_eq("idle_i_busy", {31'b0, bus.i_busy}, 32'd1);
        check_eq("idle_m_ren",  {31'b0, bus.m_ren},  32'd0);
        tick();

        // Fetch alone, three wait cycles
        bus.i_addr = 32'h8000_0000; bus.i_ren = 1'b1; bus.m_busy = 1'b1; bus.m_rdata = 32'h0000_0013;
        push_i(32'h8000_0000, 32'h0000_0013);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.m_busy = 1'b0;
            @(negedge CLK);
            check_eq("fetch_owner",  {30'b0, bus.owner},  (c == 0) ? 32'd0 : 32'd1);
            check_eq("fetch_m_ren",  {31'b0, bus.m_ren},  32'd1);
            check_eq("fetch_i_busy", {31'b0, bus.i_busy}, (c == 3) ? 32'd0 : 32'd1);
            tick();
        end
        bus.i_ren = 1'b0; bus.m_busy = 1'b1;
        @(negedge CLK);
        check_eq("fetch_after_owner", {30'b0, bus.owner}, 32'd0);
        tick();

        // Collision: data write wins, fetch follows after one idle cycle
        log_q.delete();
        bus.i_ren = 1'b1; bus.i_addr = 32'h8000_0004;
        bus.d_wen = 1'b1; bus.d_addr = 32'h0000_1000; bus.d_wdata = 32'hDEAD_BEEF; bus.d_byte_en = 4'h3;
        bus.m_busy = 1'b1; bus.m_rdata = 32'h1111_1111;
        push_d(32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 4'h3, 32'h1111_1111);
        push_i(32'h8000_0004, 32'h2222_2222);
        @(negedge CLK);
        check_eq("col_m_wen",   {31'b0, bus.m_wen},  32'd1);
        check_eq("col_m_ren",   {31'b0, bus.m_ren},  32'd0);
        check_eq("col_m_wdata", bus.m_wdata,         32'hDEAD_BEEF);
        check_eq("col_m_be",    {28'b0, bus.m_byte_en}, 32'h3);
        check_eq("col_i_busy",  {31'b0, bus.i_busy}, 32'd1);
        tick();
        @(negedge CLK);
        check_eq("col_owner_d", {30'b0, bus.owner}, 32'd2);
        tick();
        bus.m_busy = 1'b0;
        @(negedge CLK);
        check_eq("col_i_wait", {31'b0, bus.i_busy}, 32'd1);
        tick();
        bus.d_wen = 1'b0; bus.m_busy = 1'b1; bus.m_rdata = 32'h2222_2222;
        @(negedge CLK);
        check_eq("col_gap_owner", {30'b0, bus.owner}, 32'd0);
        check_eq("col_f_addr",    bus.m_addr,          32'h8000_0004);
        tick();
        bus.m_busy = 1'b0;
        @(negedge CLK);
        check_eq("col_owner_i", {30'b0, bus.owner}, 32'd1);
        tick();
        bus.i_ren = 1'b0; bus.m_busy = 1'b1;
        @(negedge CLK);
        check_eq("col_order_n", log_q.size(), 32'd2);
        if (log_q.size() == 2) begin
            check_eq("col_order_0", {24'b0, log_q[0]}, 32'h44);
            check_eq("col_order_1", {24'b0, log_q[1]}, 32'h49);
        end
        tick();

        // Zero-wait data reads
        bus.m_busy = 1'b0; bus.d_wdata = '0; bus.d_byte_en = 4'hF;
        for (int k = 0; k < 6; k++) begin
            bus.d_ren   = (k % 2 == 0);
            bus.d_addr  = 32'h0000_2000 + 32'(4 * k);
            bus.m_rdata = 32'h0000_3000 + 32'(k);
            if (bus.d_ren) push_d(bus.d_addr, 32'h0, 1'b0, 4'hF, bus.m_rdata);
            @(negedge CLK);
            check_eq("zw_owner",  {30'b0, bus.owner},  32'd0);
            check_eq("zw_d_busy", {31'b0, bus.d_busy}, {31'b0, ~bus.d_ren});
            tick();
        end
        bus.d_ren = 1'b0;

        nRST = 1'b0;
        tick();
        nRST = 1'b1;

        // Both ports hold requests with zero-wait memory
        bus.i_ren = 1'b1; bus.d_ren = 1'b1;
        bus.i_addr = 32'h8000_0100; bus.d_addr = 32'h0000_4000; bus.d_byte_en = 4'hF;
        bus.m_busy = 1'b0;
        for (int c = 0; c < 15; c++) begin
            bus.m_rdata = 32'h0000_5000 + 32'(c);
`ifdef ARB_FAIRNESS_EN
            exp_fetch = (c % 5 == 4);
`else
            exp_fetch = 1'b0;
`endif
            if (exp_fetch) push_i(32'h8000_0100, bus.m_rdata);
            else           push_d(32'h0000_4000, 32'h0, 1'b0, 4'hF, bus.m_rdata);
            @(negedge CLK);
            check_eq("fair_i_busy", {31'b0, bus.i_busy}, {31'b0, ~exp_fetch});
            check_eq("fair_d_busy", {31'b0, bus.d_busy}, {31'b0, exp_fetch});
            tick();
        end
        bus.i_ren = 1'b0; bus.d_ren = 1'b0;

        // Owner abandons its request mid-transaction
        bus.i_ren = 1'b1; bus.i_addr = 32'h8000_0200; bus.m_busy = 1'b1;
        @(negedge CLK);
        check_eq("drop_m_ren0", {31'b0, bus.m_ren}, 32'd1);
        tick();
        @(negedge CLK);
        check_eq("drop_owner", {30'b0, bus.owner}, 32'd1);
        tick();
        bus.i_ren = 1'b0;
        @(negedge CLK);
        check_eq("drop_m_ren",  {31'b0, bus.m_ren},  32'd0);
        check_eq("drop_i_busy", {31'b0, bus.i_busy}, 32'd1);
        tick();
        @(negedge CLK);
        check_eq("drop_idle", {30'b0, bus.owner}, 32'd0);
        tick();

        // Reset in the middle of a data write
        bus.d_wen = 1'b1; bus.d_addr = 32'h0000_1004; bus.d_wdata = 32'hCAFE_F00D; bus.m_busy = 1'b1;
        tick();
        @(negedge CLK);
        check_eq("mrst_owner_d", {30'b0, bus.owner}, 32'd2);
        tick();
        nRST = 1'b0;
        @(negedge CLK);
        check_eq("mrst_m_wen",  {31'b0, bus.m_wen},  32'd0);
        check_eq("mrst_d_busy", {31'b0, bus.d_busy}, 32'd1);
        tick();
        @(negedge CLK);
        check_eq("mrst_owner",   {30'b0, bus.owner},  32'd0);
        check_eq("mrst_d_busy2", {31'b0, bus.d_busy}, 32'd1);
        check_eq("mrst_m_wen2",  {31'b0, bus.m_wen},  32'd0);
        tick();
        bus.d_wen = 1'b0; nRST = 1'b1;
        @(negedge CLK);
        check_eq("post_owner", {30'b0, bus.owner}, 32'd0);
        tick();

        check_eq("iq_drained", iq.size(), 32'd0);
        check_eq("dq_drained", dq.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
